// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock controller: FSM state encoding,
// reset divide ratio and pulse-counter width.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } clk_state_e;

  localparam int unsigned DEFAULT_DIV = 100_000;
  localparam int unsigned CE_COUNT_W  = 16;

endpackage

// File: rtl/cpu_clock_controller_if.sv
// Control/status bundle between the CPU/board side (master) and the clock
// controller (slave).
interface cpu_clock_controller_if #(
  parameter int unsigned DIV_W = 32
);
  import clk_ctrl_pkg::*;

  logic                  mode_run;
  logic                  step_btn;
  logic                  halt_req;
  logic                  resume;
  logic                  div_load;
  logic [DIV_W-1:0]      div_value;
  logic                  div_ack;
  logic                  cpu_ce;
  logic                  phase_out;
  logic [1:0]            state;
  logic [CE_COUNT_W-1:0] ce_count;

  modport master (
    output mode_run, step_btn, halt_req, resume, div_load, div_value,
    input  div_ack, cpu_ce, phase_out, state, ce_count
  );

  modport slave (
    input  mode_run, step_btn, halt_req, resume, div_load, div_value,
    output div_ack, cpu_ce, phase_out, state, ce_count
  );

endinterface

// File: rtl/step_debouncer.sv
// Debounces the synchronized step button: the output level follows the input
// only after the input has held a new level for DEBOUNCE_CYCLES cycles.
module step_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic level_in,
  output logic level_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // Any return to the stable level (a bounce) restarts the qualification window.
    if (level_in != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = level_in;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level_out = stable_q;

endmodule

// File: rtl/cpu_clock_controller.sv
// CPU clock-enable sequencer: free-run divider, single-step button and halt.
// Define STEP_DEBOUNCE_EN to insert step_debouncer in the step-button path.
module cpu_clock_controller
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W           = 32,
  parameter int unsigned DEFAULT_DIV     = clk_ctrl_pkg::DEFAULT_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                   clk_in,
  input logic                   rst,
  cpu_clock_controller_if.slave bus
);

  if (DIV_W < 2 || DEBOUNCE_CYCLES == 0) begin : g_bad_params
    $error("cpu_clock_controller: DIV_W must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  clk_state_e            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DIV_W-1:0]      count_q, count_d;
  logic                  cpu_ce_q, cpu_ce_d;
  logic                  div_ack_q, div_ack_d;
  logic                  phase_q, phase_d;
  logic [CE_COUNT_W-1:0] ce_count_q, ce_count_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  level_prev_q, level_prev_d;
  logic                  step_level;
  logic                  step_edge;
  logic                  terminal;

`ifdef STEP_DEBOUNCE_EN
  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk_in   (clk_in),
    .rst      (rst),
    .level_in (sync2_q),
    .level_out(step_level)
  );
`else
  assign step_level = sync2_q;
`endif

  assign terminal  = (count_q == div_q - DIV_W'(1));
  assign step_edge = step_level & ~level_prev_q;

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sync1_d      = bus.step_btn;
    sync2_d      = sync1_q;
    level_prev_d = step_level;
    state_d      = state_q;
    div_d        = div_q;
    count_d      = count_q;
    cpu_ce_d     = 1'b0;
    div_ack_d    = 1'b0;

    // One event per cycle, highest priority first; a lower event in the same
    // cycle is dropped, which is how halt and load swallow a pending pulse.
    if (bus.halt_req) begin
      state_d = HALTED;
      count_d = '0;
    end else if (bus.div_load) begin
      div_d     = (bus.div_value > DIV_W'(1)) ? bus.div_value : DIV_W'(1);
      count_d   = '0;
      div_ack_d = 1'b1;
    end else begin
      unique case (state_q)
        HALTED: begin
          count_d = '0;
          if (bus.resume) state_d = bus.mode_run ? RUN : STEP;
        end
        RUN: begin
          if (!bus.mode_run) begin
            state_d = STEP;
            count_d = '0;
          end else if (terminal) begin
            count_d  = '0;
            cpu_ce_d = 1'b1;
          end else begin
            count_d = count_q + DIV_W'(1);
          end
        end
        STEP: begin
          count_d = '0;
          if (bus.mode_run) state_d = RUN;
          else if (step_edge) cpu_ce_d = 1'b1;
        end
        default: begin
          state_d = HALTED;
          count_d = '0;
        end
      endcase
    end

    // Built from next-state values so phase_out tracks the live counter.
    phase_d    = (state_d == RUN) && (count_d >= (div_d >> 1));
    ce_count_d = ce_count_q + CE_COUNT_W'(cpu_ce_d);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= HALTED;
      div_q        <= DIV_W'(DEFAULT_DIV);
      count_q      <= '0;
      cpu_ce_q     <= 1'b0;
      div_ack_q    <= 1'b0;
      phase_q      <= 1'b0;
      ce_count_q   <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      count_q      <= count_d;
      cpu_ce_q     <= cpu_ce_d;
      div_ack_q    <= div_ack_d;
      phase_q      <= phase_d;
      ce_count_q   <= ce_count_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_prev_q <= level_prev_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.cpu_ce    = cpu_ce_q;
  assign bus.div_ack   = div_ack_q;
  assign bus.phase_out = phase_q;
  assign bus.ce_count  = ce_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: a timeline model checked every
// cycle plus directed vectors with literal expectations.
module tb_cpu_clock_controller;
  import clk_ctrl_pkg::*;

  localparam int unsigned DIV_W          = 32;
  // Reset ratio shortened so the reset-then-run scenario fits the run time.
  localparam int unsigned TB_DEFAULT_DIV = 2000;

  logic clk_in = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  cpu_clock_controller_if #(.DIV_W(DIV_W)) bus ();

  cpu_clock_controller #(
    .DIV_W          (DIV_W),
    .DEFAULT_DIV    (TB_DEFAULT_DIV),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Timeline model: cpu_ce pulses fall on multiples of the ratio counted from
  // the edge that started the current period; step edges are the button
  // sampled two edges ago rising against the sample before it.
  longint      m_cyc    = 0;
  longint      m_origin = 0;
  logic [31:0] m_div    = TB_DEFAULT_DIV;
  int          m_state  = 0;
  logic        m_ce     = 1'b0;
  logic        m_ack    = 1'b0;
  logic        m_phase  = 1'b0;
  logic [15:0] m_cnt    = '0;
  logic [3:0]  m_btn    = '0;
  bit          m_valid  = 1'b0;

  always @(posedge clk_in) begin
    longint elapsed;
    logic   step_rise;
    m_cyc++;
    if (rst) begin
      m_state = 0;
      m_div   = TB_DEFAULT_DIV;
      m_ce    = 1'b0;
      m_ack   = 1'b0;
      m_cnt   = '0;
      m_btn   = '0;
      m_origin = m_cyc;
      m_valid = 1'b1;
    end else begin
      m_btn     = {m_btn[2:0], bus.step_btn};
      step_rise = m_btn[2] & ~m_btn[3];
      elapsed   = m_cyc - m_origin;
      m_ce      = 1'b0;
      m_ack     = 1'b0;
      if (bus.halt_req) begin
        m_state = 0;
      end else if (bus.div_load) begin
        m_div    = (bus.div_value < 2) ? 32'd1 : bus.div_value;
        m_origin = m_cyc;
        m_ack    = 1'b1;
      end else if (m_state == 0) begin
        if (bus.resume) begin
          m_state  = bus.mode_run ? 1 : 2;
          m_origin = m_cyc;
        end
      end else if (m_state == 1) begin
        if (!bus.mode_run) m_state = 2;
        else if (elapsed % longint'(m_div) == 0) m_ce = 1'b1;
      end else begin
        if (bus.mode_run) begin
          m_state  = 1;
          m_origin = m_cyc;
        end else if (step_rise) begin
          m_ce = 1'b1;
        end
      end
      if (m_ce) m_cnt = m_cnt + 16'd1;
    end
    m_phase = (m_state == 1) &&
              (((m_cyc - m_origin) % longint'(m_div)) >= longint'(m_div / 2));
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      check("model_state", 32'(bus.state), 32'(m_state));
      check("model_cpu_ce", 32'(bus.cpu_ce), 32'(m_ce));
      check("model_div_ack", 32'(bus.div_ack), 32'(m_ack));
      check("model_phase", 32'(bus.phase_out), 32'(m_phase));
      check("model_ce_count", 32'(bus.ce_count), 32'(m_cnt));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first;
    int budget;
    rst           = 1'b1;
    bus.mode_run  = 1'b0;
    bus.step_btn  = 1'b0;
    bus.halt_req  = 1'b0;
    bus.resume    = 1'b0;
    bus.div_load  = 1'b0;
    bus.div_value = '0;
    tick(3);
    rst = 1'b0;

    // Reset and idle.
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    end
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_ce_count", 32'(bus.ce_count), 32'd0);
    check("reset_phase", 32'(bus.phase_out), 32'd0);

    // Free-run at ratio 4.
    bus.div_value = 32'd4;
    bus.div_load  = 1'b1;
    tick(1);
    bus.div_load  = 1'b0;
    check("load4_ack", 32'(bus.div_ack), 32'd1);
    tick(1);
    check("load4_ack_single", 32'(bus.div_ack), 32'd0);
    bus.mode_run = 1'b1;
    bus.resume   = 1'b1;
    tick(1);
    bus.resume   = 1'b0;
    check("run_entry_state", 32'(bus.state), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      check($sformatf("run_ce_%0d", i), 32'(bus.cpu_ce), 32'((i % 4) == 0));
      check($sformatf("run_phase_%0d", i), 32'(bus.phase_out), 32'((i % 4) >= 2));
    end
    check("run_ce_count", 32'(bus.ce_count), 32'd3);

    // Ratio 0 behaves as 1: a pulse on every cycle after the load.
    bus.div_value = 32'd0;
    bus.div_load  = 1'b1;
    tick(1);
    bus.div_load  = 1'b0;
    check("deg_ack", 32'(bus.div_ack), 32'd1);
    check("deg_no_ce_on_load", 32'(bus.cpu_ce), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check($sformatf("deg_ce_%0d", i), 32'(bus.cpu_ce), 32'd1);
      check($sformatf("deg_count_%0d", i), 32'(bus.ce_count), 32'(3 + i));
    end

    // Single-step: one pulse, in the 3rd cycle after the first high sample.
    bus.mode_run = 1'b0;
    tick(1);
    check("step_entry_state", 32'(bus.state), 32'd2);
    check("step_entry_no_ce", 32'(bus.cpu_ce), 32'd0);
    tick(2);
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check($sformatf("step_ce_%0d", i), 32'(bus.cpu_ce), 32'(i == 3));
    end
    bus.step_btn = 1'b0;
    tick(4);
    check("step_ce_count", 32'(bus.ce_count), 32'd9);

    // A press while halted is neither pulsed nor queued.
    bus.halt_req = 1'b1;
    tick(1);
    bus.halt_req = 1'b0;
    check("halt_from_step", 32'(bus.state), 32'd0);
    bus.step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check($sformatf("halted_press_ce_%0d", i), 32'(bus.cpu_ce), 32'd0);
    end
    bus.step_btn = 1'b0;
    tick(4);
    bus.resume = 1'b1;
    tick(1);
    bus.resume = 1'b0;
    check("resume_to_step", 32'(bus.state), 32'd2);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check($sformatf("no_queued_ce_%0d", i), 32'(bus.cpu_ce), 32'd0);
    end
    check("halted_press_count", 32'(bus.ce_count), 32'd9);

    // halt_req on the terminal-count cycle wins over the pulse.
    bus.halt_req = 1'b1;
    tick(1);
    bus.halt_req  = 1'b0;
    bus.div_value = 32'd4;
    bus.div_load  = 1'b1;
    tick(1);
    bus.div_load  = 1'b0;
    bus.mode_run  = 1'b1;
    bus.resume    = 1'b1;
    tick(1);
    bus.resume    = 1'b0;
    tick(3);
    bus.halt_req = 1'b1;
    tick(1);
    bus.halt_req = 1'b0;
    check("halt_tc_no_ce", 32'(bus.cpu_ce), 32'd0);
    check("halt_tc_state", 32'(bus.state), 32'd0);
    check("halt_tc_count", 32'(bus.ce_count), 32'd9);
    bus.halt_req = 1'b1;
    bus.resume   = 1'b1;
    tick(1);
    bus.halt_req = 1'b0;
    bus.resume   = 1'b0;
    check("halt_resume_same_cycle", 32'(bus.state), 32'd0);

    // ce_count wrap at ratio 1.
    bus.div_value = 32'd1;
    bus.div_load  = 1'b1;
    tick(1);
    bus.div_load  = 1'b0;
    bus.resume    = 1'b1;
    tick(1);
    bus.resume    = 1'b0;
    budget = 0;
    while (bus.ce_count != 16'hFFFE && budget < 70_000) begin
      tick(1);
      budget++;
    end
    check("wrap_reach_fffe", 32'(bus.ce_count), 32'h0000_FFFE);
    tick(1);
    check("wrap_ffff", 32'(bus.ce_count), 32'h0000_FFFF);
    tick(1);
    check("wrap_zero", 32'(bus.ce_count), 32'h0000_0000);
    check("wrap_ce", 32'(bus.cpu_ce), 32'd1);

    // Reset mid-period restores the default ratio.
    bus.div_value = 32'd4;
    bus.div_load  = 1'b1;
    tick(1);
    bus.div_load  = 1'b0;
    tick(2);
    rst = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick(1);
      check($sformatf("rst_ce_%0d", i), 32'(bus.cpu_ce), 32'd0);
      check($sformatf("rst_state_%0d", i), 32'(bus.state), 32'd0);
      check($sformatf("rst_count_%0d", i), 32'(bus.ce_count), 32'd0);
    end
    rst = 1'b0;
    tick(2);
    check("post_rst_state", 32'(bus.state), 32'd0);
    bus.resume = 1'b1;
    tick(1);
    bus.resume = 1'b0;
    first = -1;
    for (int i = 1; i <= int'(TB_DEFAULT_DIV) + 10; i++) begin
      tick(1);
      if (bus.cpu_ce && first < 0) first = i;
    end
    check("rst_default_first_ce", 32'(first), TB_DEFAULT_DIV);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
